// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with word-by-word line refill.
// Define ICACHE_STATS_EN to add the saturating hit-cycle and miss counters.
module icache_direct #(
    parameter int LINE_BITS = 6,
    parameter int WORD_BITS = 2
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_data,
    output logic        icache_rdy,
    input  logic        icache_flush,
`ifdef ICACHE_STATS_EN
    output logic [31:0] stat_hit_cycles,
    output logic [31:0] stat_misses,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);
    localparam int LINES  = 1 << LINE_BITS;
    localparam int WORDS  = 1 << WORD_BITS;
    localparam int TAG_W  = 30 - LINE_BITS - WORD_BITS;
    localparam int BASE_W = 30 - WORD_BITS;

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [31:0]       data [LINES*WORDS];

    logic [WORD_BITS-1:0] cnt;
    logic [BASE_W-1:0]    base;
    logic                 flush_pending;

    logic [WORD_BITS-1:0] off;
    logic [LINE_BITS-1:0] idx;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] ref_idx;
    logic [TAG_W-1:0]     ref_tag;
    logic                 hit;
    logic                 start;
    logic                 unused;

    assign off     = icache_addr[WORD_BITS+1:2];
    assign idx     = icache_addr[WORD_BITS+LINE_BITS+1:WORD_BITS+2];
    assign tag     = icache_addr[31:WORD_BITS+LINE_BITS+2];
    assign ref_idx = base[LINE_BITS-1:0];
    assign ref_tag = base[BASE_W-1:LINE_BITS];
    assign unused  = ^icache_addr[1:0];

    assign hit         = (state == IDLE) && valid[idx] && (tags[idx] == tag);
    assign start       = (state == IDLE) && !hit && !icache_flush;
    assign icache_rdy  = hit;
    assign icache_data = hit ? data[{idx, off}] : 32'h0;
    assign mem_addr    = {base, cnt, 2'b00};

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state         <= IDLE;
            valid         <= '0;
            cnt           <= '0;
            mem_en        <= 1'b0;
            base          <= '0;
            flush_pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (icache_flush) begin
                        valid <= '0;
                    end
                    if (start) begin
                        base   <= icache_addr[31:WORD_BITS+2];
                        cnt    <= '0;
                        mem_en <= 1'b1;
                        state  <= REFILL;
                    end
                end
                REFILL: begin
                    if (icache_flush) begin
                        flush_pending <= 1'b1;
                        valid         <= '0;
                    end
                    if (mem_rdy) begin
                        cnt <= cnt + 1'b1;
                        // a flush seen at any point of the refill leaves the line invalid
                        if (&cnt) begin
                            valid[ref_idx] <= !flush_pending && !icache_flush;
                            flush_pending  <= 1'b0;
                            mem_en         <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ctrl_clk) begin
        if (state == REFILL && mem_rdy) begin
            data[{ref_idx, cnt}] <= mem_rdata;
            if (&cnt) begin
                tags[ref_idx] <= ref_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            stat_hit_cycles <= '0;
            stat_misses     <= '0;
        end else begin
            if (icache_rdy && stat_hit_cycles != 32'hFFFFFFFF) begin
                stat_hit_cycles <= stat_hit_cycles + 32'd1;
            end
            if (start && stat_misses != 32'hFFFFFFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: scoreboard bench for icache_direct with a stalling memory model.
// Expected hits and refill addresses are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_icache_direct;
    logic        ctrl_clk;
    logic        ctrl_reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_rdy;
    logic        icache_flush;
    logic [31:0] mem_addr;
    logic        mem_en;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit_cycles;
    logic [31:0] stat_misses;
`endif

    icache_direct dut (
        .ctrl_clk(ctrl_clk),
        .ctrl_reset(ctrl_reset),
        .icache_addr(icache_addr),
        .icache_data(icache_data),
        .icache_rdy(icache_rdy),
        .icache_flush(icache_flush),
`ifdef ICACHE_STATS_EN
        .stat_hit_cycles(stat_hit_cycles),
        .stat_misses(stat_misses),
`endif
        .mem_addr(mem_addr),
        .mem_en(mem_en),
        .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy)
    );

    int checks = 0;
    int fails  = 0;
    int stall  = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_ma[$];

    logic        p_en   = 1'b0;
    logic        p_rdy  = 1'b0;
    logic [31:0] p_addr = 32'h0;
    logic        pen;
    logic        acc;
    int          wcnt = 0;

    initial begin
        ctrl_clk = 1'b0;
        forever #5 ctrl_clk = ~ctrl_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h100: return 32'hA0;
            32'h104: return 32'hA1;
            32'h108: return 32'hA2;
            32'h10C: return 32'hA3;
            32'h500: return 32'hB0;
            32'h504: return 32'hB1;
            32'h508: return 32'hB2;
            32'h50C: return 32'hB3;
            default: return a ^ 32'h5A5A0000;
        endcase
    endfunction

    // memory: waits `stall` cycles per word, then accepts with data
    initial begin
        mem_rdy   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge ctrl_clk);
            pen = mem_en;
            acc = mem_en && mem_rdy;
            #1;
            wcnt      = (!pen || acc) ? 0 : wcnt + 1;
            mem_rdy   = mem_en && (wcnt >= stall);
            mem_rdata = mem_val(mem_addr);
        end
    end

    initial begin
        forever begin
            @(negedge ctrl_clk);
            if (icache_rdy) begin
                chk("hit_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) chk("hit_data", icache_data, exp_rd.pop_front());
            end else begin
                chk("data_zero", icache_data, 32'h0);
            end
            if (mem_en && mem_rdy) begin
                chk("mem_expected", 32'(exp_ma.size() != 0), 32'd1);
                if (exp_ma.size() != 0) chk("mem_addr", mem_addr, exp_ma.pop_front());
            end
            if (mem_en && p_en && !p_rdy) chk("mem_addr_hold", mem_addr, p_addr);
            p_en   = mem_en;
            p_rdy  = mem_rdy;
            p_addr = mem_addr;
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int refills,
                         input int st, input int lat, input int fc);
        int n;
        stall        = st;
        icache_addr  = a;
        icache_flush = (fc == 0);
        for (int r = 0; r < refills; r++)
            for (int w = 0; w < 4; w++)
                exp_ma.push_back({a[31:4], 4'h0} + 32'(4 * w));
        exp_rd.push_back(d);
        n = 0;
        forever begin
            @(negedge ctrl_clk);
            if (icache_rdy || n > 100) break;
            n++;
            @(posedge ctrl_clk);
            #1;
            icache_flush = (n == fc);
        end
        chk($sformatf("latency_%h", a), 32'(n), 32'(lat));
        @(posedge ctrl_clk);
        #1;
        icache_flush = 1'b0;
    endtask

    task automatic hold(input logic [31:0] a, input logic [31:0] d, input int n);
        icache_addr = a;
        repeat (n) begin
            exp_rd.push_back(d);
            @(posedge ctrl_clk);
            #1;
        end
    endtask

    initial begin
        ctrl_reset   = 1'b1;
        icache_addr  = 32'h0;
        icache_flush = 1'b0;
        repeat (2) @(posedge ctrl_clk);
        #1;
        chk("reset_rdy", 32'(icache_rdy), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        ctrl_reset = 1'b0;

        fetch(32'h100, 32'hA0, 1, 0, 5, -1);
        fetch(32'h10C, 32'hA3, 0, 0, 0, -1);
        fetch(32'h500, 32'hB0, 1, 0, 5, -1);
        fetch(32'h100, 32'hA0, 1, 0, 5, -1);
        fetch(32'h208, 32'h5A5A0208, 1, 3, 17, -1);
        fetch(32'h20C, 32'h5A5A020C, 0, 0, 0, -1);
        fetch(32'h100, 32'hA0, 0, 0, 0, 0);
        fetch(32'h100, 32'hA0, 1, 0, 6, 0);
        fetch(32'h500, 32'hB0, 1, 0, 5, -1);
        fetch(32'h100, 32'hA0, 2, 0, 10, 2);
        fetch(32'h500, 32'hB0, 2, 0, 10, 4);
        fetch(32'h504, 32'hB1, 0, 0, 0, -1);

        icache_addr = 32'h600;
        exp_ma.push_back(32'h600);
        exp_ma.push_back(32'h604);
        repeat (3) @(posedge ctrl_clk);
        #2;
        chk("pre_reset_mem_en", 32'(mem_en), 32'd1);
        chk("pre_reset_mem_addr", mem_addr, 32'h608);
        ctrl_reset = 1'b1;
        #1;
        chk("async_mem_en", 32'(mem_en), 32'd0);
        chk("async_mem_addr", mem_addr, 32'h0);
        chk("async_rdy", 32'(icache_rdy), 32'd0);
        @(posedge ctrl_clk);
        #1;
        ctrl_reset = 1'b0;
        fetch(32'h100, 32'hA0, 1, 0, 5, -1);
        hold(32'h100, 32'hA0, 9);
`ifdef ICACHE_STATS_EN
        chk("stat_misses", stat_misses, 32'd1);
        chk("stat_hit_cycles", stat_hit_cycles, 32'd10);
`endif
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("ma_queue_empty", 32'(exp_ma.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the instruction-memory bus.
- Fetch side: fetch presents its PC on icache_addr; the cache answers hits combinationally in the same cycle.
- On a miss, icache_rdy is held low (fetch stalls the pipeline) while a full line is refilled, one word at a time, over a simple request/ready memory handshake.

Parameters:
- LINE_BITS, 6, log2 of line count (default 64 lines).
- WORD_BITS, 2, log2 of 32-bit words per line (default 4 words = 16 bytes).

Ports:
- ctrl_clk  input  1  clock; all state updates on rising edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- icache_addr  input  32  fetch address (PC); bits [1:0] ignored.
- icache_data  output  32  instruction word; 0 whenever icache_rdy=0.
- icache_rdy  output  1  hit: icache_data valid this cycle.
- icache_flush  input  1  one-cycle pulse; invalidates all lines (FENCE.I).
- mem_addr  output  32  word-aligned refill address.
- mem_en  output  1  refill request.
- mem_rdata  input  32  refill data; valid in a cycle with mem_rdy=1.
- mem_rdy  input  1  memory accepts the request and returns data this cycle.

Behaviour:
- Address split:
  - off = addr[WORD_BITS+1:2]
  - idx = addr[WORD_BITS+LINE_BITS+1:WORD_BITS+2]
  - tag = addr[31:WORD_BITS+LINE_BITS+2]
- Storage:
  - valid[2^LINE_BITS], tag array, data array [2^LINE_BITS][2^WORD_BITS].
  - Combinational read of all three.
- State machine IDLE / REFILL:
  - Reset: state IDLE, all valid=0, cnt=0, mem_en=0, mem_addr=0, refill_base=0, flush_pending=0.
  - Outputs take reset values immediately (asynchronous), including mid-refill.
  - IDLE: hit = valid[idx] && tag[idx]==tag(addr).
    - icache_rdy = hit; icache_data = data[idx][off] on a hit, else 0.
    - mem_en=0.
  - IDLE and !hit and !icache_flush: at the next edge, latch refill_base = {addr[31:WORD_BITS+2], zeros}, cnt=0, go to REFILL.
  - REFILL: icache_rdy=0, mem_en=1, mem_addr = refill_base + 4*cnt.
    - mem_addr and mem_en stay stable until mem_rdy.
    - On mem_rdy: data[ref_idx][cnt] <= mem_rdata, cnt++.
    - On the last word (cnt == 2^WORD_BITS-1 with mem_rdy):
      - tag[ref_idx] <= ref_tag; valid[ref_idx] <= !flush_pending && !icache_flush.
      - flush_pending <= 0; cnt <= 0; go to IDLE.
  - Refill is never aborted except by reset. A change of icache_addr during REFILL does not affect the refill in progress; the new address is looked up in IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss with mem_rdy tied high: rdy returns 2^WORD_BITS+1 cycles after the miss cycle (5 for the defaults).
- Flush:
  - In IDLE: all valid cleared at the edge. icache_rdy stays combinational from the pre-edge valid bits in that cycle; no refill starts in the flush cycle.
  - In REFILL: set flush_pending and clear all valid bits at the edge. The in-flight line completes its data writes but stays invalid, so the next lookup misses and refills again.
- Simultaneous events:
  - Flush in the same cycle as the last refill word: that line ends invalid.
  - Reset dominates everything.
- Write path: none. The cache is not coherent with data stores; software issues a flush.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs stat_hit_cycles [31:0] and stat_misses [31:0], both reset to 0.
  - stat_hit_cycles +1 each cycle icache_rdy=1.
  - stat_misses +1 on each IDLE->REFILL transition.
  - Both saturate at 32'hFFFFFFFF; flush does not clear them.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Test Plan:
- Cold miss: after reset, addr=0x00000100, mem_rdy=1, mem returns 0xA0..0xA3.
  - mem_addr = 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - rdy=1 with data=0xA0 on cycle 5; addr 0x10C then hits with 0xA3, no mem_en.
- Conflict: after the line at 0x100 is filled, addr=0x00000500 (same idx, different tag) -> miss, refill at 0x500..0x50C; then 0x100 misses again.
- Backpressure: mem_rdy low for 3 cycles per word -> mem_addr/mem_en hold stable; refill takes 16 cycles; data correct.
- Flush during refill: pulse icache_flush during the 2nd refill word of 0x100 -> refill completes; the following lookup of 0x100 misses and a second refill occurs.
- Async reset mid-refill (cnt=2): mem_en drops in the same cycle without a clock edge; after release, addr=0x100 misses (valid cleared).
- ICACHE_STATS_EN: cold miss, then 10 hit cycles -> stat_misses=1, stat_hit_cycles=10.
